// File: rtl/shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// shared_reg_arbiter
//
// Round-robin arbiter that owns one shared, clock-enabled storage register.
// Each requester writes the register through a four-phase REQ/GNT/ACK
// handshake: IDLE picks a winner, GRANT performs the single write, and
// RELEASE holds the grant until the winner drops its request.
//
// Ports:
//   CLK    in   1           clock, rising edge
//   RSTN   in   1           asynchronous active-low reset
//   REQ    in   NREQ        per-requester write request (level)
//   D      in   NREQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
//   GNT    out  NREQ        one-hot grant (registered)
//   ACK    out  1           one-cycle pulse after the register is written
//   OWNER  out  OW          index of the granted requester, 0 when idle
//   BUSY   out  1           high whenever the FSM is not in IDLE
//   Q      out  WIDTH       shared register value
//   QN     out  WIDTH       ~Q (combinational)
// -----------------------------------------------------------------------------
module shared_reg_arbiter #(
    parameter int                 NREQ          = 4,
    parameter int                 WIDTH         = 8,
    parameter logic [WIDTH-1:0]   INITIAL_VALUE = {WIDTH{1'b0}},
    localparam int                OW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLK,
    input  logic                  RSTN,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] D,
    output logic [NREQ-1:0]       GNT,
    output logic                  ACK,
    output logic [OW-1:0]         OWNER,
    output logic                  BUSY,
    output logic [WIDTH-1:0]      Q,
    output logic [WIDTH-1:0]      QN
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GRANT   = 2'b01,
        ST_RELEASE = 2'b10
    } state_t;

    state_t            r_state;
    logic [NREQ-1:0]   r_gnt;
    logic [OW-1:0]     r_owner;
    logic              r_ack;
    logic              r_busy;
    logic [OW-1:0]     r_ptr;
    logic [WIDTH-1:0]  r_q;

    state_t            w_state_nxt;
    logic [NREQ-1:0]   w_gnt_nxt;
    logic [OW-1:0]     w_owner_nxt;
    logic              w_ack_nxt;
    logic [OW-1:0]     w_ptr_nxt;
    logic              w_ce;
    logic [OW-1:0]     w_win;
    logic [WIDTH-1:0]  w_wdata;
    logic              w_req_win;

    // Round-robin winner search: scan from the highest offset down so the
    // requester closest to r_ptr (lowest offset) is the last assignment.
    always_comb begin
        int         idx;
        logic [OW-1:0] idx_v;
        w_win = {OW{1'b0}};
        idx   = 0;
        idx_v = {OW{1'b0}};
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx   = (int'(r_ptr) + k >= NREQ) ? (int'(r_ptr) + k - NREQ) : (int'(r_ptr) + k);
            idx_v = OW'(idx);
            if (REQ[idx_v]) begin
                w_win = idx_v;
            end else begin
                w_win = w_win;
            end
        end
    end

    // Request level and write data of the current owner.
    always_comb begin
        w_wdata   = {WIDTH{1'b0}};
        w_req_win = REQ[r_owner];
        for (int i = 0; i < NREQ; i++) begin
            if (r_owner == OW'(i)) begin
                w_wdata = D[i*WIDTH +: WIDTH];
            end else begin
                w_wdata = w_wdata;
            end
        end
    end

    // Next-state and registered-output logic of the handshake FSM.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ack_nxt   = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_ce        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|REQ) begin
                    w_gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
                    w_owner_nxt = w_win;
                    // Pointer advances at grant time, even if the grant is later aborted.
                    w_ptr_nxt   = (int'(w_win) == NREQ - 1) ? {OW{1'b0}} : (w_win + OW'(1));
                    w_state_nxt = ST_GRANT;
                end else begin
                    w_gnt_nxt   = {NREQ{1'b0}};
                    w_owner_nxt = {OW{1'b0}};
                end
            end
            ST_GRANT: begin
                if (w_req_win) begin
                    w_ce        = 1'b1;
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_RELEASE;
                end else begin
                    // Winner withdrew before the write: abort without touching Q.
                    w_gnt_nxt   = {NREQ{1'b0}};
                    w_owner_nxt = {OW{1'b0}};
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (w_req_win) begin
                    w_state_nxt = ST_RELEASE;
                end else begin
                    w_gnt_nxt   = {NREQ{1'b0}};
                    w_owner_nxt = {OW{1'b0}};
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_gnt_nxt   = {NREQ{1'b0}};
                w_owner_nxt = {OW{1'b0}};
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, handshake outputs and round-robin pointer.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state <= ST_IDLE;
            r_gnt   <= {NREQ{1'b0}};
            r_owner <= {OW{1'b0}};
            r_ack   <= 1'b0;
            r_busy  <= 1'b0;
            r_ptr   <= {OW{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ack   <= w_ack_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Shared storage register; the only write path is the GRANT-cycle enable.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_q <= INITIAL_VALUE;
        end else if (w_ce) begin
            r_q <= w_wdata;
        end else begin
            r_q <= r_q;
        end
    end

    assign GNT   = r_gnt;
    assign ACK   = r_ack;
    assign OWNER = r_owner;
    assign BUSY  = r_busy;
    assign Q     = r_q;
    assign QN    = ~r_q;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_shared_reg_arbiter
//
// Table of {REQ, D, expected outputs} rows applied one clock each; expected
// outputs are queued when a row is driven and popped after the clock edge.
// Hand-written sequences cover reset behaviour, including reset mid-transaction.
// -----------------------------------------------------------------------------
module tb_shared_reg_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;

    logic                  CLK = 1'b0;
    logic                  RSTN;
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] D;
    logic [NREQ-1:0]       GNT;
    logic                  ACK;
    logic [1:0]            OWNER;
    logic                  BUSY;
    logic [WIDTH-1:0]      Q;
    logic [WIDTH-1:0]      QN;

    shared_reg_arbiter #(
        .NREQ          (NREQ),
        .WIDTH         (WIDTH),
        .INITIAL_VALUE (8'hA5)
    ) dut (
        .CLK   (CLK),
        .RSTN  (RSTN),
        .REQ   (REQ),
        .D     (D),
        .GNT   (GNT),
        .ACK   (ACK),
        .OWNER (OWNER),
        .BUSY  (BUSY),
        .Q     (Q),
        .QN    (QN)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       ack;
        logic       busy;
        logic [7:0] q;
    } exp_t;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] d;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t tv[$];
    int   n_pass  = 0;
    int   n_total = 0;

    localparam logic [31:0] DRR = 32'h44332211;
    localparam logic [31:0] DS  = 32'h443C2211;
    localparam logic [31:0] DA  = 32'h445E2211;
    localparam logic [31:0] DH1 = 32'h445E7711;
    localparam logic [31:0] DH2 = 32'h445E8811;
    localparam logic [31:0] DH3 = 32'h995E8811;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic compare_out(input string tag);
        exp_t       e;
        logic [7:0] eqn;
        if (sb.size() == 0) begin
            chk({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e   = sb.pop_front();
            eqn = ~e.q;
            chk({tag, ".gnt"},   {28'd0, GNT},   {28'd0, e.gnt});
            chk({tag, ".owner"}, {30'd0, OWNER}, {30'd0, e.owner});
            chk({tag, ".ack"},   {31'd0, ACK},   {31'd0, e.ack});
            chk({tag, ".busy"},  {31'd0, BUSY},  {31'd0, e.busy});
            chk({tag, ".q"},     {24'd0, Q},     {24'd0, e.q});
            chk({tag, ".qn"},    {24'd0, QN},    {24'd0, eqn});
        end
    endtask

    // Drive one row at the falling edge, check after the following rising edge.
    task automatic step(input string tag, input logic [3:0] req, input logic [31:0] d, input exp_t e);
        sb.push_back(e);
        REQ = req;
        D   = d;
        @(posedge CLK);
        @(negedge CLK);
        compare_out(tag);
    endtask

    function automatic exp_t ex(input logic [3:0] g, input logic [1:0] o, input logic a,
                                input logic b, input logic [7:0] q);
        exp_t e;
        e.gnt = g; e.owner = o; e.ack = a; e.busy = b; e.q = q;
        return e;
    endfunction

    function automatic vec_t v(input logic [3:0] r, input logic [31:0] d, input exp_t e);
        vec_t t;
        t.req = r; t.d = d; t.e = e;
        return t;
    endfunction

    initial begin
        // Round-robin from reset (PTR=0): grants 0,1,2,3,0, each dropping after ACK.
        tv.push_back(v(4'b1111, DRR, ex(4'b0001, 2'd0, 1'b0, 1'b1, 8'hA5)));
        tv.push_back(v(4'b1111, DRR, ex(4'b0001, 2'd0, 1'b1, 1'b1, 8'h11)));
        tv.push_back(v(4'b1110, DRR, ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h11)));
        tv.push_back(v(4'b1111, DRR, ex(4'b0010, 2'd1, 1'b0, 1'b1, 8'h11)));
        tv.push_back(v(4'b1111, DRR, ex(4'b0010, 2'd1, 1'b1, 1'b1, 8'h22)));
        tv.push_back(v(4'b1101, DRR, ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h22)));
        tv.push_back(v(4'b1111, DRR, ex(4'b0100, 2'd2, 1'b0, 1'b1, 8'h22)));
        tv.push_back(v(4'b1111, DRR, ex(4'b0100, 2'd2, 1'b1, 1'b1, 8'h33)));
        tv.push_back(v(4'b1011, DRR, ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h33)));
        tv.push_back(v(4'b1111, DRR, ex(4'b1000, 2'd3, 1'b0, 1'b1, 8'h33)));
        tv.push_back(v(4'b1111, DRR, ex(4'b1000, 2'd3, 1'b1, 1'b1, 8'h44)));
        tv.push_back(v(4'b0111, DRR, ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h44)));
        tv.push_back(v(4'b1111, DRR, ex(4'b0001, 2'd0, 1'b0, 1'b1, 8'h44)));
        tv.push_back(v(4'b1111, DRR, ex(4'b0001, 2'd0, 1'b1, 1'b1, 8'h11)));
        tv.push_back(v(4'b1110, DRR, ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h11)));
        tv.push_back(v(4'b0000, DRR, ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h11)));
        // Single write by requester 2 with D=3C (PTR=1 -> 3).
        tv.push_back(v(4'b0100, DS,  ex(4'b0100, 2'd2, 1'b0, 1'b1, 8'h11)));
        tv.push_back(v(4'b0100, DS,  ex(4'b0100, 2'd2, 1'b1, 1'b1, 8'h3C)));
        tv.push_back(v(4'b0000, DS,  ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h3C)));
        // Abort: requester 1 granted (PTR 3 -> 2), drops REQ during GRANT.
        tv.push_back(v(4'b0010, DS,  ex(4'b0010, 2'd1, 1'b0, 1'b1, 8'h3C)));
        tv.push_back(v(4'b0000, DS,  ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h3C)));
        // Advanced PTR=2: requester 2 wins over 0 and 1.
        tv.push_back(v(4'b0111, DS,  ex(4'b0100, 2'd2, 1'b0, 1'b1, 8'h3C)));
        tv.push_back(v(4'b0111, DA,  ex(4'b0100, 2'd2, 1'b1, 1'b1, 8'h5E)));
        tv.push_back(v(4'b0000, DA,  ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h5E)));
        // Hold: requester 1 (PTR 3 -> 2) keeps REQ 5 cycles after ACK, REQ[3] pending.
        tv.push_back(v(4'b0010, DA,  ex(4'b0010, 2'd1, 1'b0, 1'b1, 8'h5E)));
        tv.push_back(v(4'b1010, DH1, ex(4'b0010, 2'd1, 1'b1, 1'b1, 8'h77)));
        for (int i = 0; i < 5; i++)
            tv.push_back(v(4'b1010, DH2, ex(4'b0010, 2'd1, 1'b0, 1'b1, 8'h77)));
        tv.push_back(v(4'b1000, DH2, ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h77)));
        tv.push_back(v(4'b1000, DH2, ex(4'b1000, 2'd3, 1'b0, 1'b1, 8'h77)));
        tv.push_back(v(4'b1000, DH3, ex(4'b1000, 2'd3, 1'b1, 1'b1, 8'h99)));
        tv.push_back(v(4'b0000, DH3, ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h99)));

        // Reset with the clock running and requests asserted.
        RSTN = 1'b0;
        REQ  = 4'b1111;
        D    = DRR;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            sb.push_back(ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'hA5));
            compare_out($sformatf("rst%0d", i));
        end
        RSTN = 1'b1;
        REQ  = 4'b0000;

        for (int i = 0; i < tv.size(); i++)
            step($sformatf("v%0d", i), tv[i].req, tv[i].d, tv[i].e);

        // Reset mid-transaction: grant requester 2 (PTR 0 -> 3), reset in GRANT.
        step("m_grant", 4'b0100, DH3, ex(4'b0100, 2'd2, 1'b0, 1'b1, 8'h99));
        RSTN = 1'b0;
        #1;
        sb.push_back(ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'hA5));
        compare_out("m_async");
        @(posedge CLK);
        @(negedge CLK);
        sb.push_back(ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'hA5));
        compare_out("m_held");
        RSTN = 1'b1;
        // PTR back at 0 so requester 1 wins over 3.
        step("m_g1",  4'b1010, DH3, ex(4'b0010, 2'd1, 1'b0, 1'b1, 8'hA5));
        step("m_w1",  4'b1010, DH3, ex(4'b0010, 2'd1, 1'b1, 1'b1, 8'h88));
        step("m_r1",  4'b1000, DH3, ex(4'b0000, 2'd0, 1'b0, 1'b0, 8'h88));
        step("m_g3",  4'b1000, DH3, ex(4'b1000, 2'd3, 1'b0, 1'b1, 8'h88));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
